// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
//   UART receiver front end for 8N1 frames. The raw serial pin is
//   synchronised, start bits are validated at half a bit time, and data and
//   stop bits are sampled at mid-bit. A good byte is presented on `data` with
//   a one-cycle `valid` strobe. A stop bit that samples 0 gives a one-cycle
//   `frame_err` strobe. The receiver then waits for the line to return high,
//   so a held-low break reports only one error.
//
// Parameters:
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      line rate in bit/s (CLK_FREQ/BAUD must be >= 4)
//
// Ports:
//   clk        system clock, rising-edge
//   rst        asynchronous active-high reset
//   din        raw serial line, idle high, asynchronous to clk
//   valid      one-cycle pulse when a good frame completes
//   data       last good byte, held until the next valid
//   frame_err  one-cycle pulse when the stop bit samples 0
//   busy       registered, high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t        state;
  logic          din_meta;
  logic          din_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  // Two-flop synchroniser on the raw pin; resets to the idle (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_meta <= 1'b1;
      din_s    <= 1'b1;
    end else begin
      din_meta <= din;
      din_s    <= din_meta;
    end
  end

  // Receive state machine with bit timer, bit index, shift register and
  // registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= CNT_ZERO;
      idx       <= 3'd0;
      sh        <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Strobes default low so each one lasts only a single cycle.
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= CNT_ZERO;
          if (!din_s) begin
            state <= START;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end

        // Re-check the line at the centre of the start bit to reject glitches.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= CNT_ZERO;
            if (!din_s) begin
              state <= DATA;
              idx   <= 3'd0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // The timer is aligned to mid-bit, so every full bit period lands
        // in the centre of the next bit.
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= CNT_ZERO;
            sh[idx] <= din_s;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Leaving at mid stop bit gives half a bit of slack, which lets a
        // back-to-back start bit be caught.
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= CNT_ZERO;
            if (din_s) begin
              data  <= sh;
              valid <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // A held-low line (break) must go high again before a new start
        // can be recognised.
        WAIT_IDLE: begin
          cnt <= CNT_ZERO;
          if (din_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            busy  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= CNT_ZERO;
          idx   <= 3'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
module tb_uart_rx_sampler;

  logic       clk;
  logic       rst;
  logic       din;
  logic       valid;
  logic [7:0] data;
  logic       frame_err;
  logic       busy;

  int n_checks;
  int n_fail;
  int cyc;
  int vcount;
  int fcount;
  int overlap;
  logic [7:0] vdata [0:31];
  int         vcyc  [0:31];

  uart_rx_sampler #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .valid     (valid),
    .data      (data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record output strobes at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      if (vcount < 32) begin
        vdata[vcount] = data;
        vcyc[vcount]  = cyc;
      end
      vcount = vcount + 1;
    end
    if (frame_err) fcount = fcount + 1;
    if (valid && frame_err) overlap = overlap + 1;
  end

  // Must be called right after a negedge. Returns at a negedge.
  // e = index of the last rising edge before the start bit was driven.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int e);
    din = 1'b0;
    e = cyc;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (16) @(negedge clk);
    end
    din = stop_bit;
    repeat (16) @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    din = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    din = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
    rst = 1'b0;
    idle_cycles(8);
  endtask

  task automatic test_single;
    int e, v0, f0;
    v0 = vcount; f0 = fcount;
    send_frame(8'h55, 1'b1, e);
    idle_cycles(20);
    n_checks++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL single_valid_count: got %0d expected 1", vcount - v0); end
    n_checks++; if (vdata[v0] !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h expected 55", vdata[v0]); end
    // T0 is three edges after the pin is driven; valid follows T0 by 152.
    n_checks++; if (vcyc[v0] !== e + 155) begin n_fail++; $display("FAIL single_timing: got %0d expected %0d", vcyc[v0], e + 155); end
    n_checks++; if (fcount - f0 !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d expected 0", fcount - f0); end
    n_checks++; if (data !== 8'h55) begin n_fail++; $display("FAIL single_data_held: got %h expected 55", data); end
  endtask

  task automatic test_back_to_back;
    int e1, e2, v0;
    v0 = vcount;
    send_frame(8'hA3, 1'b1, e1);
    send_frame(8'h0F, 1'b1, e2);
    idle_cycles(20);
    n_checks++; if (vcount - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 2", vcount - v0); end
    n_checks++; if (vdata[v0] !== 8'hA3) begin n_fail++; $display("FAIL b2b_data0: got %h expected a3", vdata[v0]); end
    n_checks++; if (vdata[v0+1] !== 8'h0F) begin n_fail++; $display("FAIL b2b_data1: got %h expected 0f", vdata[v0+1]); end
    n_checks++; if (vcyc[v0+1] - vcyc[v0] !== 160) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 160", vcyc[v0+1] - vcyc[v0]); end
  endtask

  task automatic test_glitch;
    int e, v0, f0;
    v0 = vcount; f0 = fcount;
    din = 1'b0;
    e = cyc;
    repeat (5) @(negedge clk);
    din = 1'b1;
    // T0 = e+3: busy high right after it.
    while (cyc < e + 3) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b expected 1", busy); end
    // Start check at T0+8 sees the line high again.
    while (cyc < e + 12) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall: got %b expected 0", busy); end
    idle_cycles(200);
    n_checks++; if (vcount - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", vcount - v0); end
    n_checks++; if (fcount - f0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d expected 0", fcount - f0); end
  endtask

  task automatic test_frame_error;
    int e, v0, f0;
    v0 = vcount; f0 = fcount;
    send_frame(8'h3C, 1'b1, e);
    idle_cycles(4);
    send_frame(8'h81, 1'b0, e);
    idle_cycles(40);
    n_checks++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL ferr_valid_count: got %0d expected 1", vcount - v0); end
    n_checks++; if (fcount - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", fcount - f0); end
    n_checks++; if (data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data_kept: got %h expected 3c", data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_break;
    int e, v0, f0;
    v0 = vcount; f0 = fcount;
    din = 1'b0;
    repeat (20 * 16) @(negedge clk);
    idle_cycles(32);
    n_checks++; if (fcount - f0 !== 1) begin n_fail++; $display("FAIL break_frame_err: got %0d expected 1", fcount - f0); end
    send_frame(8'h7E, 1'b1, e);
    idle_cycles(20);
    n_checks++; if (fcount - f0 !== 1) begin n_fail++; $display("FAIL break_frame_err_total: got %0d expected 1", fcount - f0); end
    n_checks++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL break_valid_count: got %0d expected 1", vcount - v0); end
    n_checks++; if (vdata[v0] !== 8'h7E) begin n_fail++; $display("FAIL break_data: got %h expected 7e", vdata[v0]); end
    n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d expected 0", overlap); end
  endtask

  task automatic test_reset_mid_frame;
    int e, v0, f0;
    v0 = vcount; f0 = fcount;
    // Frame of 0xFF: start bit, then the line stays high.
    din = 1'b0;
    e = cyc;
    repeat (16) @(negedge clk);
    din = 1'b1;
    // Bit 4 is sampled at edge e+91; reset lands inside that bit.
    while (cyc < e + 85) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00", data); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_err: got %b expected 0", frame_err); end
    rst = 1'b0;
    while (cyc < e + 200) @(negedge clk);
    n_checks++; if (vcount - v0 !== 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d expected 0", vcount - v0); end
    n_checks++; if (fcount - f0 !== 0) begin n_fail++; $display("FAIL rstmid_no_ferr: got %0d expected 0", fcount - f0); end
    send_frame(8'h12, 1'b1, e);
    idle_cycles(20);
    n_checks++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL rstmid_valid_count: got %0d expected 1", vcount - v0); end
    n_checks++; if (vdata[v0] !== 8'h12) begin n_fail++; $display("FAIL rstmid_next_data: got %h expected 12", vdata[v0]); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    vcount   = 0;
    fcount   = 0;
    overlap  = 0;
    rst      = 1'b1;
    din      = 1'b1;
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_error;
    test_break;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
